// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, flag bit positions, FSM states.
// Optional feature macro: ALU_SEQ_SHIFT_EN (adds the iterative shifter state).
package alu_pkg;

  typedef enum logic [3:0] {
    OP_NOT = 4'd0,
    OP_AND = 4'd1,
    OP_OR  = 4'd2,
    OP_XOR = 4'd3,
    OP_DEC = 4'd4,
    OP_ADD = 4'd5,
    OP_SUB = 4'd6,
    OP_INC = 4'd7,
    OP_SHL = 4'd8,
    OP_SHR = 4'd9,
    OP_SAR = 4'd10
  } alu_op_e;

  // Bit positions inside the {Z, N, C, V} flag vector
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

`ifdef ALU_SEQ_SHIFT_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DONE  = 2'd2
  } state_e;
`endif

  // True for the three shift opcodes
  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_SAR);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational evaluation of opcodes 0-7 (logic and add/sub family).
// Anything else reports legal_o = 0 with zero result and flags.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] res_o,
  output logic [3:0]       flags_o,
  output logic             legal_o
);

  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic             c_s;
  logic             v_s;

  // INC/DEC reuse the adder/subtractor with B forced to one
  always_comb begin
    b_eff_s = b_i;
    if ((op_i == OP_INC) || (op_i == OP_DEC)) begin
      b_eff_s = {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      b_eff_s = b_i;
    end
    sum_s  = {1'b0, a_i} + {1'b0, b_eff_s};
    diff_s = {1'b0, a_i} - {1'b0, b_eff_s};
  end

  // Opcode decode: result, carry/borrow and signed overflow
  always_comb begin
    res_o   = {WIDTH{1'b0}};
    c_s     = 1'b0;
    v_s     = 1'b0;
    legal_o = 1'b1;
    case (op_i)
      OP_NOT: res_o = ~a_i;
      OP_AND: res_o = a_i & b_i;
      OP_OR:  res_o = a_i | b_i;
      OP_XOR: res_o = a_i ^ b_i;
      OP_ADD, OP_INC: begin
        res_o = sum_s[WIDTH-1:0];
        c_s   = sum_s[WIDTH];
        v_s   = (a_i[WIDTH-1] == b_eff_s[WIDTH-1]) && (sum_s[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB, OP_DEC: begin
        res_o = diff_s[WIDTH-1:0];
        c_s   = diff_s[WIDTH];
        v_s   = (a_i[WIDTH-1] != b_eff_s[WIDTH-1]) && (diff_s[WIDTH-1] != a_i[WIDTH-1]);
      end
      default: legal_o = 1'b0;
    endcase
  end

  // Flag packing; an illegal opcode yields all-zero flags
  always_comb begin
    flags_o = 4'b0000;
    if (legal_o) begin
      flags_o[FLAG_Z] = (res_o == {WIDTH{1'b0}});
      flags_o[FLAG_N] = res_o[WIDTH-1];
      flags_o[FLAG_C] = c_s;
      flags_o[FLAG_V] = v_s;
    end else begin
      flags_o = 4'b0000;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU with accumulator feedback.
// Optional feature macro: ALU_SEQ_SHIFT_EN builds the 1-bit-per-cycle shifter.
module alu_seq
  import alu_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic             use_acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic [WIDTH-1:0] a_eff_s;
  logic [WIDTH-1:0] core_res_s;
  logic [3:0]       core_flags_s;
  logic             core_legal_s;
  logic [SHW-1:0]   amt_s;
  logic             shift_op_s;

`ifdef ALU_SEQ_SHIFT_EN
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [3:0]       sop_q, sop_d;
  logic             carry_q, carry_d;
  assign shift_op_s = is_shift_op(op);
`else
  assign shift_op_s = 1'b0;
`endif

  assign a_eff_s = use_acc ? acc_q : a;
  assign amt_s   = b[SHW-1:0];

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op_i    (op),
    .a_i     (a_eff_s),
    .b_i     (b),
    .res_o   (core_res_s),
    .flags_o (core_flags_s),
    .legal_o (core_legal_s)
  );

  // Flags for a pass-through or shifted value: Z/N from the value, given carry, no overflow
  function automatic logic [3:0] plain_flags(input logic [WIDTH-1:0] r, input logic c);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_Z] = (r == {WIDTH{1'b0}});
    f[FLAG_N] = r[WIDTH-1];
    f[FLAG_C] = c;
    return f;
  endfunction

  // Next-state and datapath load logic
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    err_d    = err_q;
    acc_d    = acc_q;
`ifdef ALU_SEQ_SHIFT_EN
    work_d   = work_q;
    cnt_d    = cnt_q;
    sop_d    = sop_q;
    carry_d  = carry_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
`ifdef ALU_SEQ_SHIFT_EN
          if (shift_op_s && (amt_s != {SHW{1'b0}})) begin
            work_d  = a_eff_s;
            cnt_d   = amt_s;
            sop_d   = op;
            carry_d = 1'b0;
            state_d = ST_SHIFT;
          end else
`endif
          if (shift_op_s) begin
            // Zero shift amount: A passes straight through, no carry
            result_d = a_eff_s;
            flags_d  = plain_flags(a_eff_s, 1'b0);
            err_d    = 1'b0;
            acc_d    = a_eff_s;
            state_d  = ST_DONE;
          end else begin
            result_d = core_res_s;
            flags_d  = core_flags_s;
            err_d    = ~core_legal_s;
            acc_d    = core_res_s;
            state_d  = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
`ifdef ALU_SEQ_SHIFT_EN
      ST_SHIFT: begin
        if (cnt_q != {SHW{1'b0}}) begin
          cnt_d = cnt_q - {{(SHW-1){1'b0}}, 1'b1};
          case (sop_q)
            OP_SHL: begin
              carry_d = work_q[WIDTH-1];
              work_d  = {work_q[WIDTH-2:0], 1'b0};
            end
            OP_SHR: begin
              carry_d = work_q[0];
              work_d  = {1'b0, work_q[WIDTH-1:1]};
            end
            OP_SAR: begin
              carry_d = work_q[0];
              work_d  = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            end
            default: begin
              carry_d = carry_q;
              work_d  = work_q;
            end
          endcase
        end else begin
          result_d = work_q;
          flags_d  = plain_flags(work_q, carry_q);
          err_d    = 1'b0;
          acc_d    = work_q;
          state_d  = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, result and accumulator registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= {WIDTH{1'b0}};
      flags_q  <= 4'b0000;
      err_q    <= 1'b0;
      acc_q    <= {WIDTH{1'b0}};
`ifdef ALU_SEQ_SHIFT_EN
      work_q   <= {WIDTH{1'b0}};
      cnt_q    <= {SHW{1'b0}};
      sop_q    <= 4'd0;
      carry_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      err_q    <= err_d;
      acc_q    <= acc_d;
`ifdef ALU_SEQ_SHIFT_EN
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      sop_q    <= sop_d;
      carry_q  <= carry_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign flags     = flags_q;
  assign err       = err_q;

endmodule
